// File: rtl/eth_rx_frame.sv
// rtl/eth_rx_frame.sv - Ethernet RX framer: preamble/SFD strip, FCS/length/RX_ER check, status and counters; optional ETH_RX_STRIP_FCS_EN
module eth_rx_frame #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic [1:0] ctl_in,
  output logic [7:0] data_out,
  output logic [1:0] ctl_out,
  output logic [7:0] good_count,
  output logic [7:0] bad_count
);

  localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
  localparam logic [10:0] LEN_SAT     = 11'h7FF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_dv;
  logic        w_er;
  logic        w_start;
  logic        w_byte;
  logic        w_end;
  logic        w_frame_good;
  logic        w_fwd_valid;
  logic [7:0]  w_fwd_data;

  logic [31:0] r_crc;
  logic [10:0] r_len;
  logic        r_er_flag;
  logic [7:0]  r_data_out;
  logic [1:0]  r_ctl_out;
  logic [7:0]  r_good_count;
  logic [7:0]  r_bad_count;

  // RX_ER is only meaningful while RX_DV is high; er without dv never reaches the frame logic
  assign w_dv = ctl_in[0];
  assign w_er = ctl_in[0] ^ ctl_in[1];

  // One reflected CRC-32 step over a byte, LSB first
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Next-state decode plus the per-cycle frame events (SFD seen, data byte, end of frame)
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_byte  = 1'b0;
    w_end   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dv) begin
          w_next = (data_in == 8'h55) ? S_PREAMBLE : S_DROP;
        end
      end
      S_PREAMBLE: begin
        if (!w_dv) begin
          w_next = S_IDLE;
        end else if (data_in == 8'h55) begin
          w_next = S_PREAMBLE;
        end else if (data_in == 8'hD5) begin
          w_next  = S_DATA;
          w_start = 1'b1;
        end else begin
          w_next = S_DROP;
        end
      end
      S_DATA: begin
        if (w_dv) begin
          w_byte = 1'b1;
        end else begin
          w_end  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_DROP: begin
        if (!w_dv) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // CRC, saturating length and sticky RX_ER flag, restarted on every SFD
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_crc     <= CRC_INIT;
      r_len     <= 11'd0;
      r_er_flag <= 1'b0;
    end else if (w_start) begin
      r_crc     <= CRC_INIT;
      r_len     <= 11'd0;
      r_er_flag <= 1'b0;
    end else if (w_byte) begin
      r_crc <= crc_byte(r_crc, data_in);
      if (r_len != LEN_SAT) begin
        r_len <= r_len + 11'd1;
      end
      if (w_er) begin
        r_er_flag <= 1'b1;
      end
    end
  end

  // A zero-byte frame fails the length check, so it needs no special case
  assign w_frame_good = (r_crc == CRC_RESIDUE) && (r_len >= MIN_L) &&
                        (r_len <= MAX_L) && !r_er_flag;

`ifdef ETH_RX_STRIP_FCS_EN
  logic [3:0][7:0] r_dly;
  logic [2:0]      r_dly_cnt;

  // Four-byte delay line: a byte leaves only once four newer bytes exist, so the FCS never does
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dly     <= '0;
      r_dly_cnt <= 3'd0;
    end else if (w_start) begin
      r_dly_cnt <= 3'd0;
    end else if (w_byte) begin
      r_dly <= {r_dly[2:0], data_in};
      if (r_dly_cnt != 3'd4) begin
        r_dly_cnt <= r_dly_cnt + 3'd1;
      end
    end
  end

  assign w_fwd_valid = w_byte && (r_dly_cnt == 3'd4);
  assign w_fwd_data  = r_dly[3];
`else
  assign w_fwd_valid = w_byte;
  assign w_fwd_data  = data_in;
`endif

  // Registered byte/status output; data_out holds its last value when not forwarding
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= 8'h00;
      r_ctl_out  <= 2'b00;
    end else if (w_fwd_valid) begin
      r_data_out <= w_fwd_data;
      r_ctl_out  <= 2'b11;
    end else if (w_end) begin
      r_ctl_out  <= w_frame_good ? 2'b01 : 2'b10;
    end else begin
      r_ctl_out  <= 2'b00;
    end
  end

  // Frame counters update on the same edge that raises the status code
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_good_count <= 8'd0;
      r_bad_count  <= 8'd0;
    end else if (w_end) begin
      if (w_frame_good) begin
        r_good_count <= r_good_count + 8'd1;
      end else begin
        r_bad_count  <= r_bad_count + 8'd1;
      end
    end
  end

  assign data_out   = r_data_out;
  assign ctl_out    = r_ctl_out;
  assign good_count = r_good_count;
  assign bad_count  = r_bad_count;

endmodule
